// File: rtl/imm_ext_queue.sv
// Multi-mode immediate extender (sign/zero/upper/branch) feeding a DEPTH-entry valid/ready queue.
// Optional same-cycle bypass when empty is enabled by defining IMM_EXT_BYPASS_EN.
module imm_ext_queue #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_W-1:0]            in_imm,
  input  logic [1:0]                 in_mode,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_imm,
  output logic                       out_neg,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned ExtW = OUT_W - IN_W;

  logic [OUT_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  logic [OUT_W-1:0] sext, ext_imm;
  logic             empty, full;
  logic             bypass, push, pop;

  always_comb begin
    sext = {{ExtW{in_imm[IN_W-1]}}, in_imm};
    ext_imm = '0;
    unique case (in_mode)
      2'b00: ext_imm = sext;
      2'b01: ext_imm = {{ExtW{1'b0}}, in_imm};
      2'b10: ext_imm = {in_imm, {ExtW{1'b0}}};
      2'b11: ext_imm = {sext[OUT_W-3:0], 2'b00};
      default: ext_imm = '0;
    endcase
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(DEPTH));

`ifdef IMM_EXT_BYPASS_EN
  // Empty queue with a ready consumer: hand the input straight through, never store it.
  assign bypass = empty & in_valid & out_ready & ~flush;
`else
  assign bypass = 1'b0;
`endif

  assign in_ready = ~full;
  assign push     = in_valid & ~full & ~bypass;
  assign pop      = ~empty & out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= ext_imm;
  end

  always_comb begin
    out_valid = ~empty | bypass;
    if (bypass)      out_imm = ext_imm;
    else if (!empty) out_imm = mem_q[rd_ptr_q];
    else             out_imm = '0;
  end

  assign out_neg = out_imm[OUT_W-1];
  assign count   = count_q;

endmodule

// File: tb/tb_imm_ext_queue.sv
// Directed self-checking bench for imm_ext_queue at default parameters (16 -> 32, depth 2).
module tb_imm_ext_queue;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic        out_neg;
  logic [1:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  imm_ext_queue dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_imm   (out_imm),
    .out_neg   (out_neg),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_imm = '0; in_mode = '0; flush = 1'b0; out_ready = 1'b0;
    #12;
    n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_checks++; if (out_imm !== 32'h0) begin n_fail++; $display("FAIL reset_out_imm got %h exp 0", out_imm); end
    n_checks++; if (out_neg !== 1'b0) begin n_fail++; $display("FAIL reset_out_neg got %b exp 0", out_neg); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    @(negedge clk); rst_n = 1'b1;
    #1;
  endtask

  task automatic test_sign();
    in_valid = 1'b1; in_imm = 16'hF234; in_mode = 2'b00; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    n_checks++; if (count !== 2'd1) begin n_fail++; $display("FAIL sign_count got %0d exp 1", count); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sign_valid got %b exp 1", out_valid); end
    n_checks++; if (out_imm !== 32'hFFFFF234) begin n_fail++; $display("FAIL sign_imm got %h exp fffff234", out_imm); end
    n_checks++; if (out_neg !== 1'b1) begin n_fail++; $display("FAIL sign_neg got %b exp 1", out_neg); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL sign_pop_count got %0d exp 0", count); end
    n_checks++; if (out_imm !== 32'h0) begin n_fail++; $display("FAIL sign_pop_imm got %h exp 0", out_imm); end
  endtask

  task automatic test_modes();
    in_valid = 1'b1; in_imm = 16'h8000; in_mode = 2'b01; out_ready = 1'b0;
    step();
    n_checks++; if (out_imm !== 32'h00008000) begin n_fail++; $display("FAIL zero_imm got %h exp 00008000", out_imm); end
    n_checks++; if (out_neg !== 1'b0) begin n_fail++; $display("FAIL zero_neg got %b exp 0", out_neg); end
    in_mode = 2'b10; out_ready = 1'b1;
    step();
    n_checks++; if (out_imm !== 32'h80000000) begin n_fail++; $display("FAIL upper_imm got %h exp 80000000", out_imm); end
    n_checks++; if (count !== 2'd1) begin n_fail++; $display("FAIL upper_count got %0d exp 1", count); end
    in_mode = 2'b11;
    step();
    n_checks++; if (out_imm !== 32'hFFFE0000) begin n_fail++; $display("FAIL branch_imm got %h exp fffe0000", out_imm); end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL modes_drain got %0d exp 0", count); end
  endtask

  task automatic test_full();
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'b00;
    in_imm = 16'h1111; step();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready1 got %b exp 1", in_ready); end
    in_imm = 16'h2222; in_mode = 2'b01; step();
    n_checks++; if (count !== 2'd2) begin n_fail++; $display("FAIL full_count2 got %0d exp 2", count); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready2 got %b exp 0", in_ready); end
    in_imm = 16'h3333; in_mode = 2'b00; step();
    in_valid = 1'b0;
    n_checks++; if (count !== 2'd2) begin n_fail++; $display("FAIL full_count3 got %0d exp 2", count); end
    n_checks++; if (out_imm !== 32'h00001111) begin n_fail++; $display("FAIL full_head0 got %h exp 00001111", out_imm); end
    out_ready = 1'b1; step();
    n_checks++; if (out_imm !== 32'h00002222) begin n_fail++; $display("FAIL full_head1 got %h exp 00002222", out_imm); end
    step();
    n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL full_drain got %0d exp 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL full_drain_valid got %b exp 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    in_valid = 1'b1; in_mode = 2'b00; out_ready = 1'b0;
    in_imm = 16'h0AAA; step();
    in_imm = 16'h0BBB; step();
    in_imm = 16'h0CCC; out_ready = 1'b1; step();
    n_checks++; if (count !== 2'd1) begin n_fail++; $display("FAIL fullpop_count got %0d exp 1", count); end
    n_checks++; if (out_imm !== 32'h00000BBB) begin n_fail++; $display("FAIL fullpop_head got %h exp 00000bbb", out_imm); end
    in_imm = 16'h0DDD; step();
    n_checks++; if (out_imm !== 32'h00000DDD) begin n_fail++; $display("FAIL fullpop_next got %h exp 00000ddd (0ccc dropped)", out_imm); end
    in_valid = 1'b0; step();
    out_ready = 1'b0;
    n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL fullpop_drain got %0d exp 0", count); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v;
    in_valid = 1'b1; in_mode = 2'b01; out_ready = 1'b0;
    in_imm = 16'h0100; step();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      v = 16'h0100 + 16'(i);
      in_imm = v;
      n_checks++;
      if (out_imm !== {16'h0, v - 16'h1}) begin
        n_fail++; $display("FAIL b2b_head[%0d] got %h exp %h", i, out_imm, {16'h0, v - 16'h1});
      end
      step();
      n_checks++;
      if (count !== 2'd1) begin n_fail++; $display("FAIL b2b_count[%0d] got %0d exp 1", i, count); end
    end
    n_checks++; if (out_imm !== 32'h00000108) begin n_fail++; $display("FAIL b2b_last got %h exp 00000108", out_imm); end
    in_valid = 1'b0; step();
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    in_valid = 1'b1; in_mode = 2'b00; out_ready = 1'b0;
    in_imm = 16'h0011; step();
    in_imm = 16'h0022; step();
    n_checks++; if (count !== 2'd2) begin n_fail++; $display("FAIL flush_pre got %0d exp 2", count); end
    flush = 1'b1; in_imm = 16'h5555; step();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL flush_count got %0d exp 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b exp 0", out_valid); end
    out_ready = 1'b1; step(); step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_ghost got %b exp 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_bypass();
    in_valid = 1'b1; in_imm = 16'h7FFF; in_mode = 2'b00; out_ready = 1'b1;
    #1;
`ifdef IMM_EXT_BYPASS_EN
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL byp_valid got %b exp 1", out_valid); end
    n_checks++; if (out_imm !== 32'h00007FFF) begin n_fail++; $display("FAIL byp_imm got %h exp 00007fff", out_imm); end
    step();
    in_valid = 1'b0;
    n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL byp_count got %0d exp 0", count); end
`else
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL nobyp_valid got %b exp 0", out_valid); end
    step();
    in_valid = 1'b0;
    n_checks++; if (out_imm !== 32'h00007FFF) begin n_fail++; $display("FAIL nobyp_imm got %h exp 00007fff", out_imm); end
    n_checks++; if (count !== 2'd1) begin n_fail++; $display("FAIL nobyp_count got %0d exp 1", count); end
    step();
`endif
    out_ready = 1'b0;
    n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL byp_end got %0d exp 0", count); end
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; in_imm = 16'h1234; in_mode = 2'b00; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL areset_count got %0d exp 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid got %b exp 0", out_valid); end
    @(negedge clk); rst_n = 1'b1;
    #1;
  endtask

  initial begin
    test_reset();
    test_sign();
    test_modes();
    test_full();
    test_full_pop();
    test_back_to_back();
    test_flush();
    test_bypass();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
